// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream_if
// Description : Bundle of the FIFO read handshake, the output valid/ready
//               stream and the status signals of the read-side drain stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_stream_if #(
  parameter int WORDSIZE = 8,
  parameter int CNTSIZE  = 16
);
  // FIFO side
  logic                fifo_empty;
  logic [WORDSIZE-1:0] fifo_rdata;
  logic                signal_read;
  // Stream side
  logic                m_valid;
  logic [WORDSIZE-1:0] m_data;
  logic                m_ready;
  // Control and status
  logic                flush;
  logic [1:0]          occupancy;
  logic [CNTSIZE-1:0]  xfer_count;

  // Drain stage view
  modport master (
    input  fifo_empty, fifo_rdata, m_ready, flush,
    output signal_read, m_valid, m_data, occupancy, xfer_count
  );

  // Environment view (FIFO plus consumer)
  modport slave (
    output fifo_empty, fifo_rdata, m_ready, flush,
    input  signal_read, m_valid, m_data, occupancy, xfer_count
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Pops words from the async FIFO read port and re-presents them
//               as a registered valid/ready stream through a 2-entry buffer,
//               with synchronous flush and a transferred-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
  parameter int WORDSIZE = 8,
  parameter int CNTSIZE  = 16
) (
  input  logic             rclk,
  input  logic             rst,
  fifo_rd_stream_if.master bus
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam logic [CNTSIZE-1:0] C_CNT_ONE = {{(CNTSIZE-1){1'b0}}, 1'b1};

  logic [1:0]          r_occ;
  logic [1:0]          w_occ_next;
  logic [WORDSIZE-1:0] r_entry0;
  logic [WORDSIZE-1:0] r_entry1;
  logic [WORDSIZE-1:0] w_entry0_next;
  logic [WORDSIZE-1:0] w_entry1_next;
  logic                r_valid;
  logic [CNTSIZE-1:0]  r_xfer;
  logic                w_push;
  logic                w_pop_out;

  // Pop only from registered state so there is no combinational path from
  // m_ready back into the FIFO; reset holds the pop request low.
  assign w_push    = !rst && !bus.fifo_empty && !bus.flush && (r_occ < OCC_FULL);
  assign w_pop_out = r_valid && bus.m_ready;

  assign bus.signal_read = w_push;
  assign bus.m_valid     = r_valid;
  assign bus.m_data      = r_entry0;
  assign bus.occupancy   = r_occ;
  assign bus.xfer_count  = r_xfer;

  // Next buffer contents and occupancy; entry0 is always the head word.
  always_comb begin
    w_occ_next    = r_occ;
    w_entry0_next = r_entry0;
    w_entry1_next = r_entry1;
    if (bus.flush) begin
      w_occ_next = OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_push) begin
            w_entry0_next = bus.fifo_rdata;
            w_occ_next    = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_push && !w_pop_out) begin
            w_entry1_next = bus.fifo_rdata;
            w_occ_next    = OCC_FULL;
          end else if (w_push && w_pop_out) begin
            w_entry0_next = bus.fifo_rdata;
          end else if (w_pop_out) begin
            w_occ_next = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_pop_out) begin
            w_entry0_next = r_entry1;
            w_occ_next    = OCC_ONE;
          end
        end
        default: begin
          w_occ_next = OCC_EMPTY;
        end
      endcase
    end
  end

  // Buffer registers; m_valid is registered alongside occupancy.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      r_occ    <= OCC_EMPTY;
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_occ    <= w_occ_next;
      r_entry0 <= w_entry0_next;
      r_entry1 <= w_entry1_next;
      r_valid  <= (w_occ_next != OCC_EMPTY);
    end
  end

  // Transfer counter; a transfer on a flush edge still counts.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      r_xfer <= '0;
    end else if (w_pop_out) begin
      r_xfer <= r_xfer + C_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Self-checking bench for fifo_rd_stream. A queue stands in for
//               the async FIFO and a second queue models the buffered words.
//               Two instances (16-bit and 4-bit counters) share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rst  = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'hEE;
  logic       m_ready = 1'b0;
  logic       flush = 1'b0;

  int          total = 0;
  int          bad   = 0;
  int unsigned cnt   = 0;
  logic [7:0]  fq[$];   // words waiting in the FIFO
  logic [7:0]  mq[$];   // words held by the drain stage

  fifo_rd_stream_if #(.WORDSIZE(8), .CNTSIZE(16)) b16 ();
  fifo_rd_stream_if #(.WORDSIZE(8), .CNTSIZE(4))  b4 ();

  assign b16.fifo_empty = fifo_empty;
  assign b16.fifo_rdata = fifo_rdata;
  assign b16.m_ready    = m_ready;
  assign b16.flush      = flush;
  assign b4.fifo_empty  = fifo_empty;
  assign b4.fifo_rdata  = fifo_rdata;
  assign b4.m_ready     = m_ready;
  assign b4.flush       = flush;

  fifo_rd_stream #(.WORDSIZE(8), .CNTSIZE(16)) dut16 (.rclk(rclk), .rst(rst), .bus(b16));
  fifo_rd_stream #(.WORDSIZE(8), .CNTSIZE(4))  dut4  (.rclk(rclk), .rst(rst), .bus(b4));

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check against the model at negedge, then
  // advance FIFO and model at the rising edge.
  task automatic cycle(input logic rdy, input logic fl);
    logic       sr_exp;
    logic       pop_exp;
    logic       v_exp;
    logic [7:0] d_exp;
    m_ready    = rdy;
    flush      = fl;
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : 8'hEE;
    @(negedge rclk);
    sr_exp  = (fq.size() != 0) && !fl && (mq.size() < 2);
    v_exp   = (mq.size() != 0);
    d_exp   = v_exp ? mq[0] : 8'h00;
    pop_exp = v_exp && rdy;
    chk("signal_read", b16.signal_read, sr_exp);
    chk("occupancy", b16.occupancy, mq.size());
    chk("m_valid", b16.m_valid, v_exp);
    if (v_exp) chk("m_data", b16.m_data, d_exp);
    chk("xfer16", b16.xfer_count, cnt & 32'hFFFF);
    chk("xfer4", b4.xfer_count, cnt & 32'hF);
    chk("dut4_stream", {b4.signal_read, b4.m_valid, b4.occupancy,
                        (v_exp ? b4.m_data : 8'h00)},
        {sr_exp, v_exp, 2'(mq.size()), d_exp});
    @(posedge rclk);
    if (pop_exp) cnt++;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop_exp) void'(mq.pop_front());
      if (sr_exp) mq.push_back(fq.pop_front());
    end
    #1;
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic do_reset();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : 8'hEE;
    rst = 1'b1;
    #2;
    chk("rst_signal_read", b16.signal_read, 1'b0);
    chk("rst_m_valid", b16.m_valid, 1'b0);
    chk("rst_occupancy", b16.occupancy, 2'd0);
    chk("rst_m_data", b16.m_data, 8'h00);
    chk("rst_xfer16", b16.xfer_count, 16'd0);
    chk("rst_xfer4", b4.xfer_count, 4'd0);
    mq.delete();
    cnt = 0;
    @(posedge rclk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset with a non-empty FIFO, then stream 0x11..0x18 with m_ready high.
    for (int i = 0; i < 8; i++) fq.push_back(8'h11 + 8'(i));
    do_reset();
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0);
    chk("stream_count", b16.xfer_count, 16'd8);

    // Backpressure: 4 words, consumer stalled, then drained.
    for (int i = 0; i < 4; i++) fq.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);

    // Alternating ready with 6 words.
    for (int i = 0; i < 6; i++) fq.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 16; i++) cycle(1'(i % 2 == 0), 1'b0);

    // Flush with 0x21,0x22 buffered and 0x23 still in the FIFO.
    fq.push_back(8'h21);
    fq.push_back(8'h22);
    fq.push_back(8'h23);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);

    // Random traffic with occasional flush; counters wrap along the way.
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 2 == 0) && (fq.size() < 8)) fq.push_back(8'($urandom));
      cycle(1'($urandom % 4 != 0), 1'($urandom % 16 == 0));
    end

    // Reset mid-stream; the FIFO pointers reset alongside.
    for (int i = 0; i < 4; i++) fq.push_back(8'h40 + 8'(i));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    fq.delete();
    do_reset();

    // Exactly 17 words after reset: 4-bit counter reads 15, 0, 1.
    for (int i = 0; i < 17; i++) fq.push_back(8'h50 + 8'(i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    chk("wrap_final4", b4.xfer_count, 4'd1);
    chk("wrap_final16", b16.xfer_count, 16'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of the async FIFO, in the read clock domain.
- Pops words using the FIFO's empty / signal_read / read_data handshake and re-presents them as a registered valid/ready stream through a 2-entry buffer.
- Sustains one word per cycle at full throughput.
- Provides a synchronous flush and a running count of transferred words for the consumer.

Parameters:
- WORDSIZE, 8, data width; matches the FIFO word size.
- CNTSIZE, 16, width of the transferred-word counter.

Ports:
- rclk  input  1  read-domain clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag; read_data is valid when 0.
- fifo_rdata  input  WORDSIZE  FIFO head word (read_data); combinational from the FIFO memory.
- signal_read  output  1  FIFO pop request; the FIFO advances its read pointer on rclk when this is 1 and fifo_empty is 0.
- m_valid  output  1  output word valid.
- m_data  output  WORDSIZE  output word.
- m_ready  input  1  consumer accepts m_data when m_valid and m_ready are both 1 at a rising edge.
- flush  input  1  synchronous discard of buffered words.
- occupancy  output  2  number of words held in the buffer (0..2).
- xfer_count  output  CNTSIZE  count of completed output transfers.

Behaviour:
- Reset (asynchronous, rst=1):
  - occupancy=0, m_valid=0, m_data=0, xfer_count=0, both buffer entries=0.
  - signal_read=0 while rst is high.
- Pop rule (combinational): signal_read = !fifo_empty && !flush && (occupancy < 2).
  - Depends only on registered occupancy, flush and fifo_empty; no path from m_ready.
- Push: push = signal_read. fifo_rdata is captured on the same rising edge the FIFO pops.
- Drain: pop_out = m_valid && m_ready.
- Buffer: entry0 is the head and drives m_data; entry1 is the second word. Register update per edge, when not flushing:
  - occ 0, push: entry0<=rdata; occ->1.
  - occ 1, push, no pop_out: entry1<=rdata; occ->2.
  - occ 1, push, pop_out: entry0<=rdata; occ stays 1.
  - occ 1, pop_out only: occ->0.
  - occ 2, pop_out: entry0<=entry1; occ->1. No push is possible at occ 2.
  - Any other combination: hold.
- m_valid = (occupancy != 0), registered.
- Latency: a word popped at edge N appears on m_data with m_valid=1 after edge N (one cycle).
- Throughput: at occ=1 with m_ready held high and FIFO non-empty, one push and one pop_out occur every cycle.
- Stream rule: once m_valid=1, m_valid and m_data hold unchanged until accepted or flushed.
- Order: words leave in exact FIFO pop order; no duplication, no loss except on flush.
- Flush (synchronous, sampled at rising edge):
  - occupancy<=0, m_valid<=0.
  - signal_read is forced 0 in that cycle, so the FIFO is not popped.
  - Words still in the FIFO are untouched.
  - A transfer completing on the flush edge (m_valid && m_ready) is counted; the remaining buffer contents are discarded.
- xfer_count increments by 1 on every pop_out and wraps modulo 2^CNTSIZE (all ones -> 0). It is unaffected by flush.
- fifo_empty rising while occ<2: signal_read drops in the same cycle and no push occurs.
- Reset mid-stream: all state clears immediately; buffered words are lost and the FIFO pointers reset separately.

Test Plan:
- Reset: hold rst=1, fifo_empty=0 -> signal_read=0, m_valid=0, occupancy=0, xfer_count=0. Release rst -> signal_read=1 on the first cycle.
- Streaming: FIFO preloaded 0x11..0x18, m_ready=1 -> m_data sequence 0x11..0x18 on 8 consecutive cycles, first one cycle after the first pop; xfer_count=8; occupancy ends 0.
- Backpressure: 4 words in FIFO, m_ready=0 -> exactly 2 pops, then signal_read=0, occupancy=2, m_data holds 0x11. Set m_ready=1 -> 0x11,0x12,0x13,0x14 in order with no gaps and no duplicates.
- Alternating m_ready (1,0,1,0...) with 6 words -> all 6 delivered in order; m_data stable whenever m_valid=1 and m_ready=0.
- Flush: occupancy=2 holding 0x21,0x22, FIFO holding 0x23, m_ready=0, pulse flush one cycle -> signal_read=0 during flush, occupancy=0 and m_valid=0 next cycle, then 0x23 is popped and presented; xfer_count unchanged.
- Counter wrap: CNTSIZE=4, stream 17 words -> xfer_count reads 15 after 15 words, 0 after 16, 1 after 17.
